// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared types and constants for the staged reset generator.
//   seq_state_t   : sequencer state encoding (also exported on the debug port)
//   RESTART_CNT_W : width of the saturating restart counter
//   sat_inc       : saturating increment used for the restart counter
package reset_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_PRE     = 2'd0,
        SEQ_ASSERT  = 2'd1,
        SEQ_RELEASE = 2'd2,
        SEQ_RUN     = 2'd3
    } seq_state_t;

    localparam int RESTART_CNT_W = 8;

    function automatic logic [RESTART_CNT_W-1:0] sat_inc(input logic [RESTART_CNT_W-1:0] v);
        return (v == {RESTART_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
//   Qualifies a level input that has been high for DEBOUNCE_CYCLES consecutive
//   clock edges. Produces exactly one qualify pulse per press, no matter how
//   long the input stays high afterwards.
//
//   Ports:
//     hz100         in   clock
//     reset         in   synchronous active-high reset
//     in            in   already-synchronised level input
//     qualify_pulse out  high during the cycle whose rising edge brings the
//                        counter to DEBOUNCE_CYCLES (so the consumer acts on
//                        that very edge)
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic hz100,
    input  logic reset,
    input  logic in,
    output logic qualify_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Counts consecutive high samples, parks at CNT_MAX, clears on any low.
    always_ff @(posedge hz100) begin
        if (reset) begin
            cnt <= '0;
        end else if (!in) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Once cnt sits at CNT_MAX this can never be true again until a low
    // sample clears the counter, giving one pulse per press.
    assign qualify_pulse = in && (cnt == CNT_MAX - 1'b1);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Power-on / manual reset generator with staggered per-channel release.
//   After reset is sampled low, all NUM_CH outputs go high, stay high for
//   HOLD_CYCLES edges, then release one channel every STAGGER_CYCLES edges,
//   bit 0 first. A debounced manual request restarts the sequence; restarts
//   out of RELEASE/RUN are counted (saturating at 255).
//
//   Optional build macro RESET_SEQ_WATCHDOG_EN adds a RUN-state watchdog
//   (parameter WDT_CYCLES, input wdt_kick, output wdt_fired) that triggers
//   the same restart as a manual request when it is not kicked in time.
//
//   Ports:
//     hz100         in   clock
//     reset         in   synchronous active-high reset
//     manual        in   restart request (already synchronised)
//     wdt_kick      in   watchdog kick (watchdog build only)
//     rst_out       out  active-high reset per domain, bit 0 released first
//     seq_done      out  high while every channel is released (RUN)
//     restart_count out  qualified restarts since reset, saturating
//     wdt_fired     out  one-cycle pulse on watchdog expiry (watchdog build only)
//     state_dbg     out  current sequencer state (seq_state_t encoding)
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int HOLD_CYCLES     = 4,
    parameter int STAGGER_CYCLES  = 2,
    parameter int DEBOUNCE_CYCLES = 3
`ifdef RESET_SEQ_WATCHDOG_EN
    ,
    parameter int WDT_CYCLES      = 100
`endif
) (
    input  logic                     hz100,
    input  logic                     reset,
    input  logic                     manual,
`ifdef RESET_SEQ_WATCHDOG_EN
    input  logic                     wdt_kick,
    output logic                     wdt_fired,
`endif
    output logic [NUM_CH-1:0]        rst_out,
    output logic                     seq_done,
    output logic [RESTART_CNT_W-1:0] restart_count,
    output logic [1:0]               state_dbg
);

    localparam int HOLD_W = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
    localparam int STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int CH_W   = (NUM_CH         > 1) ? $clog2(NUM_CH)         : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH_BIT0   = NUM_CH'(1);

    seq_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STAG_W-1:0] stag_cnt;
    logic [CH_W-1:0]   ch_idx;     // next channel to release while in RELEASE
    logic              hold_freeze; // manual still held after a qualified restart

    logic manual_qualify;
    logic wdt_expire;
    logic restart_req;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .hz100        (hz100),
        .reset        (reset),
        .in           (manual),
        .qualify_pulse(manual_qualify)
    );

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    // Expiry is the edge on which the count would reach WDT_CYCLES.
    assign wdt_expire = (state == SEQ_RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);

    always_ff @(posedge hz100) begin
        if (reset) begin
            wdt_cnt   <= '0;
            wdt_fired <= 1'b0;
        end else begin
            wdt_fired <= wdt_expire;
            if ((state != SEQ_RUN) || wdt_kick || wdt_expire) begin
                wdt_cnt <= '0;
            end else begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end
        end
    end
`else
    assign wdt_expire = 1'b0;
`endif

    // Manual and watchdog restarts are merged, so a coincident pair counts once.
    // Nothing restarts from PRE: that state only exists until the first
    // edge out of reset.
    assign restart_req = (manual_qualify || wdt_expire) && (state != SEQ_PRE);

    always_ff @(posedge hz100) begin
        if (reset) begin
            state         <= SEQ_PRE;
            rst_out       <= '0;
            seq_done      <= 1'b0;
            restart_count <= '0;
            hold_cnt      <= '0;
            stag_cnt      <= '0;
            ch_idx        <= '0;
            hold_freeze   <= 1'b0;
        end else if (restart_req) begin
            state       <= SEQ_ASSERT;
            rst_out     <= '1;
            seq_done    <= 1'b0;
            hold_cnt    <= '0;
            stag_cnt    <= '0;
            ch_idx      <= '0;
            // A watchdog-only restart has manual low, so the restart edge itself
            // is the new starting point; a manual one waits for the release.
            hold_freeze <= manual_qualify;
            if ((state == SEQ_RELEASE) || (state == SEQ_RUN)) begin
                restart_count <= sat_inc(restart_count);
            end
        end else begin
            case (state)
                SEQ_PRE: begin
                    state       <= SEQ_ASSERT;
                    rst_out     <= '1;
                    hold_cnt    <= '0;
                    hold_freeze <= 1'b0;
                end

                SEQ_ASSERT: begin
                    if (hold_freeze) begin
                        // The first low sample of manual is the new start
                        // edge, so the counter is still 0 after it.
                        hold_cnt <= '0;
                        if (!manual) begin
                            hold_freeze <= 1'b0;
                        end
                    end else if (hold_cnt == HOLD_LAST) begin
                        rst_out[0] <= 1'b0;
                        stag_cnt   <= '0;
                        ch_idx     <= CH_W'(1);
                        if (NUM_CH == 1) begin
                            state    <= SEQ_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            state <= SEQ_RELEASE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                SEQ_RELEASE: begin
                    if (stag_cnt == STAG_LAST) begin
                        rst_out  <= rst_out & ~(CH_BIT0 << ch_idx);
                        stag_cnt <= '0;
                        ch_idx   <= ch_idx + 1'b1;
                        if (ch_idx == CH_LAST) begin
                            state    <= SEQ_RUN;
                            seq_done <= 1'b1;
                        end
                    end else begin
                        stag_cnt <= stag_cnt + 1'b1;
                    end
                end

                SEQ_RUN: begin
                    // Outputs hold until a restart or reset.
                end

                default: begin
                    state <= SEQ_PRE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int NUM_CH = 2;
  localparam int HOLD   = 4;
  localparam int STAG   = 2;
  localparam int DEB    = 3;
  localparam int W      = NUM_CH + 1 + 8;

  // ---------------- clock / reset / DUT ----------------
  logic hz100  = 1'b0;
  logic reset  = 1'b1;
  logic manual = 1'b0;
  logic [NUM_CH-1:0] rst_out;
  logic seq_done;
  logic [7:0] restart_count;
  logic [1:0] state_dbg;
`ifdef RESET_SEQ_WATCHDOG_EN
  logic wdt_kick = 1'b1;
  logic wdt_fired;
`endif

  reset_sequencer #(
    .NUM_CH(NUM_CH),
    .HOLD_CYCLES(HOLD),
    .STAGGER_CYCLES(STAG),
    .DEBOUNCE_CYCLES(DEB)
`ifdef RESET_SEQ_WATCHDOG_EN
    , .WDT_CYCLES(5)
`endif
  ) dut (
    .hz100(hz100),
    .reset(reset),
    .manual(manual),
`ifdef RESET_SEQ_WATCHDOG_EN
    .wdt_kick(wdt_kick),
    .wdt_fired(wdt_fired),
`endif
    .rst_out(rst_out),
    .seq_done(seq_done),
    .restart_count(restart_count),
    .state_dbg(state_dbg)
  );

  always #5 hz100 = ~hz100;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got rst_out=%b done=%b cnt=%0d, want rst_out=%b done=%b cnt=%0d",
               name, $time, got[W-1 -: NUM_CH], got[8], got[7:0],
               exp[W-1 -: NUM_CH], exp[8], exp[7:0]);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {rst_out, seq_done, restart_count};
  endfunction

  // ---------------- reference model ----------------
  // Timeline view: outputs follow from the number of edges since the
  // current start edge; m_frozen means manual is still held after a restart.
  bit m_started = 0;
  bit m_frozen  = 0;
  int m_since   = 0;
  int m_press   = 0;
  int m_restarts = 0;

  task automatic model_step(input bit r, input bit m);
    bit qual;
    bit released_phase;
    if (r) begin
      m_started = 0; m_frozen = 0; m_since = 0; m_press = 0; m_restarts = 0;
    end else begin
      if (m) begin
        if (m_press < 1000) m_press++;
      end else begin
        m_press = 0;
      end
      qual = (m_press == DEB);
      released_phase = m_started && !m_frozen && (m_since >= HOLD);
      if (!m_started) begin
        m_started = 1; m_since = 0; m_frozen = 0;
      end else if (qual) begin
        if (released_phase && m_restarts < 255) m_restarts++;
        m_frozen = 1; m_since = 0;
      end else if (m_frozen) begin
        m_since = 0;
        if (!m) m_frozen = 0;
      end else if (m_since < 100000) begin
        m_since++;
      end
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [NUM_CH-1:0] r;
    logic d;
    r = '0;
    d = 1'b0;
    if (m_started) begin
      for (int k = 0; k < NUM_CH; k++) r[k] = m_frozen || (m_since < HOLD + k * STAG);
      d = !m_frozen && (m_since >= HOLD + (NUM_CH - 1) * STAG);
    end
    return {r, d, 8'(m_restarts)};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit m);
    reset  = r;
    manual = m;
    @(posedge hz100);
    model_step(r, m);
    exp_q.push_back(model_out());
    #1;
    check("model", dut_vec(), exp_q.pop_front());
  endtask

  task automatic raw_edge(input bit r, input bit m);
    reset  = r;
    manual = m;
    @(posedge hz100);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit r;
    bit m;
    logic [NUM_CH-1:0] rst;
    bit done;
    int cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input bit r, input bit m, input logic [NUM_CH-1:0] rst,
                         input bit done, input int cnt, input int reps);
    vec_t v;
    v.r = r; v.m = m; v.rst = rst; v.done = done; v.cnt = cnt;
    for (int i = 0; i < reps; i++) vt.push_back(v);
  endtask

  initial begin
    // power-on: 2 reset edges then E0..E7
    add_vec(1, 0, 2'b00, 0, 0, 2);
    add_vec(0, 0, 2'b11, 0, 0, 4);
    add_vec(0, 0, 2'b10, 0, 0, 2);
    add_vec(0, 0, 2'b00, 1, 0, 2);
    // short press (2 high) in RUN: no effect
    add_vec(0, 1, 2'b00, 1, 0, 2);
    add_vec(0, 0, 2'b00, 1, 0, 3);
    // 10-cycle press: restart at 3rd high edge
    add_vec(0, 1, 2'b00, 1, 0, 2);
    add_vec(0, 1, 2'b11, 0, 1, 8);
    // Em .. Em+7
    add_vec(0, 0, 2'b11, 0, 1, 4);
    add_vec(0, 0, 2'b10, 0, 1, 2);
    add_vec(0, 0, 2'b00, 1, 1, 2);

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].m);
      check("table", dut_vec(), {vt[i].rst, vt[i].done, 8'(vt[i].cnt)});
    end
    check_val("state_run", int'(state_dbg), int'(SEQ_RUN));

    // mid-RELEASE reset: restart, reach rst_out=10, then reset one cycle
    for (int i = 0; i < 3; i++) step(0, 1);
    for (int i = 0; i < 5; i++) step(0, 0);
    check("pre_reset_release", dut_vec(), {2'b10, 1'b0, 8'd2});
    step(1, 0);
    check("mid_reset", dut_vec(), {2'b00, 1'b0, 8'd0});
    step(0, 0);
    check("replay_e0", dut_vec(), {2'b11, 1'b0, 8'd0});
    for (int i = 0; i < 4; i++) step(0, 0);
    check("replay_e4", dut_vec(), {2'b10, 1'b0, 8'd0});
    for (int i = 0; i < 2; i++) step(0, 0);
    check("replay_e6", dut_vec(), {2'b00, 1'b1, 8'd0});

    // qualify during power-on ASSERT: hold extended, no count
    step(1, 0);
    step(0, 0);                        // E0
    for (int i = 0; i < 3; i++) step(0, 1); // E1..E3, qualify at E3
    step(0, 0);                        // E4 = Em
    check("hold_ext_em", dut_vec(), {2'b11, 1'b0, 8'd0});
    for (int i = 0; i < 3; i++) step(0, 0);
    check("hold_ext_em3", dut_vec(), {2'b11, 1'b0, 8'd0});
    step(0, 0);
    check("hold_ext_em4", dut_vec(), {2'b10, 1'b0, 8'd0});
    for (int i = 0; i < 2; i++) step(0, 0);
    check("hold_ext_em6", dut_vec(), {2'b00, 1'b1, 8'd0});

    // saturation: 260 qualified presses from RUN
    for (int p = 0; p < 260; p++) begin
      for (int i = 0; i < 3; i++) step(0, 1);
      for (int i = 0; i < 8; i++) step(0, 0);
      if (p == 254) check_val("cnt_255", int'(restart_count), 255);
    end
    check_val("cnt_saturated", int'(restart_count), 255);

    // randomized pulses against the model
    step(1, 0);
    for (int n = 0; n < 250; n++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 6);
      lo = $urandom_range(0, 12);
      for (int i = 0; i < hi; i++) step(0, 1);
      for (int i = 0; i < lo; i++) step($urandom_range(0, 60) == 0, 0);
    end

`ifdef RESET_SEQ_WATCHDOG_EN
    // no kicks: fires 5 edges after RUN entry
    wdt_kick = 1'b0;
    raw_edge(1, 0);
    for (int i = 0; i < 7; i++) raw_edge(0, 0);   // E0..E6, RUN at E6
    check_val("wdt_run", int'(seq_done), 1);
    for (int i = 1; i <= 4; i++) raw_edge(0, 0);
    check_val("wdt_not_yet", int'(wdt_fired), 0);
    raw_edge(0, 0);
    check_val("wdt_fired", int'(wdt_fired), 1);
    check_val("wdt_rst_out", int'(rst_out), 3);
    check_val("wdt_cnt", int'(restart_count), 1);
    raw_edge(0, 0);
    check_val("wdt_pulse_end", int'(wdt_fired), 0);

    // kick every 3 cycles: never fires
    raw_edge(1, 0);
    for (int i = 0; i < 7; i++) raw_edge(0, 0);
    for (int i = 0; i < 30; i++) begin
      wdt_kick = (i % 3 == 0);
      raw_edge(0, 0);
      check_val("wdt_kicked", int'(wdt_fired), 0);
    end
    check_val("wdt_kicked_done", int'(seq_done), 1);
    wdt_kick = 1'b1;
    step(1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised power-on and manual reset generator; successor to the fixed 4-cycle startup reset used by the board top.
- Drives NUM_CH staged reset outputs, one per downstream domain, all from the single hz100 clock.
- Adds a debounced manual-restart request, staggered per-channel release, a "sequence done" flag and a saturating restart counter.
- Sits directly under the board top, between the pushbutton combo logic and the student design's reset inputs.

Parameters:
- NUM_CH, 2: number of reset outputs; must be >= 1.
- HOLD_CYCLES, 4: cycles all outputs stay high before the first release; must be >= 1.
- STAGGER_CYCLES, 2: cycles between consecutive channel releases; must be >= 1.
- DEBOUNCE_CYCLES, 3: consecutive high samples of manual needed to qualify a restart; must be >= 1.

Ports:
- hz100  input  1  system clock (100 Hz on board).
- reset  input  1  synchronous, active-high block reset.
- manual  input  1  restart request, already synchronised (e.g. pushbutton combo).
- rst_out  output  NUM_CH  active-high reset per domain; bit 0 is released first.
- seq_done  output  1  high while all channels are released (RUN state).
- restart_count  output  8  number of qualified restarts since reset; saturates at 255.

Behaviour:
- All outputs are registered. Reset is synchronous active-high, fixed.
- On reset: state = SEQ_PRE, rst_out = 0, seq_done = 0, restart_count = 0, all counters = 0. rst_out starts low so downstream logic sees a rising edge.
- Edge numbering: E0 is the first edge at which reset is sampled low.
- SEQ_PRE -> SEQ_ASSERT at E0; rst_out goes to all ones at E0.
- SEQ_ASSERT:
  - The hold counter counts edges.
  - At E0+HOLD_CYCLES, rst_out[0] clears and the state moves to SEQ_RELEASE.
- SEQ_RELEASE:
  - rst_out[k] clears at E0+HOLD_CYCLES+k*STAGGER_CYCLES.
  - A released bit never re-asserts except via restart.
  - On the edge that clears rst_out[NUM_CH-1], state = SEQ_RUN and seq_done = 1 on that same edge.
  - NUM_CH = 1: state goes to SEQ_RUN and seq_done = 1 at the same edge rst_out[0] clears.
- SEQ_RUN: outputs are stable until a restart or reset.
- Debounce:
  - A counter increments on each edge manual is sampled high, saturating at DEBOUNCE_CYCLES.
  - It clears on any edge manual is sampled low.
  - "Qualify" is the single edge at which the counter reaches DEBOUNCE_CYCLES; one qualify per press.
- Qualify, from any state except SEQ_PRE:
  - State = SEQ_ASSERT, rst_out = all ones, seq_done = 0 on that edge.
  - restart_count increments (saturating) only if the prior state was SEQ_RELEASE or SEQ_RUN.
- Qualify during SEQ_PRE is ignored; the debounce counter still runs.
- While manual stays high after qualify, the hold counter is held at 0.
- The first edge with manual sampled low acts as a new E0 for the timing above.
- A manual pulse shorter than DEBOUNCE_CYCLES has no effect on any output.
- reset mid-sequence overrides everything and returns to the reset values on that edge.

Optional Feature:
- Macro: RESET_SEQ_WATCHDOG_EN.
- Defined:
  - Adds parameter WDT_CYCLES (default 100), input wdt_kick (1 bit) and output wdt_fired (1 bit, reset 0).
  - In SEQ_RUN a watchdog counter increments each edge and clears on any edge where wdt_kick = 1.
  - When the count reaches WDT_CYCLES, the block does exactly what a qualify does, and wdt_fired pulses high for one cycle.
  - The watchdog counter clears outside SEQ_RUN.
  - If a manual qualify and a watchdog expiry fall on the same edge, only one restart is counted.
- Not defined: no wdt_kick or wdt_fired ports and no watchdog counter; behaviour is otherwise identical.

Decomposition:
- Package reset_seq_pkg:
  - typedef enum seq_state_t {SEQ_PRE, SEQ_ASSERT, SEQ_RELEASE, SEQ_RUN}.
  - localparam RESTART_CNT_W = 8.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports hz100, reset, in, qualify_pulse):
  - Holds the saturating counter and generates the single-edge qualify pulse.
  - Reusable for other pushbutton inputs.

Test Plan:
- Defaults (NUM_CH=2, HOLD=4, STAGGER=2), reset high 2 cycles then low -> rst_out = 00 during reset, 11 at E0, 10 at E4, 00 and seq_done = 1 at E6.
- In RUN, manual high for 2 cycles then low -> no change to rst_out, seq_done = 1, restart_count = 0.
- In RUN, manual high for 10 cycles -> rst_out = 11 and seq_done = 0 at the 3rd high edge, restart_count = 1. With Em the first low sample: rst_out = 10 at Em+4, 00 at Em+6.
- Manual qualify while in SEQ_ASSERT after power-on -> hold is extended, restart_count stays 0.
- Mid-RELEASE (rst_out = 10), assert reset 1 cycle -> rst_out = 00, restart_count = 0, full sequence replays from E0.
- 256 qualified presses -> restart_count saturates at 255.
- Watchdog build, WDT_CYCLES = 5, no kicks -> wdt_fired pulses 5 edges after RUN entry and rst_out = 11.
- Watchdog build, wdt_kick every 3 cycles -> watchdog never fires.
